// File: rtl/debounce_pkg.sv
// Shared types and limits for the switch debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW_STABLE,
      LOW_TO_HIGH,
      HIGH_STABLE,
      HIGH_TO_LOW
   } db_state_t;

   localparam int unsigned MIN_STABLE_CYCLES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// It uses a synchronous active-high reset to 0.
module sync_2ff (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic s1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= 1'b0;
         Q  <= 1'b0;
      end else begin
         s1 <= D;
         Q  <= s1;
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Switch debouncer: a synchronizer feeds a stability-qualified level FSM.
// Optional edge strobes are enabled by SWITCH_DEBOUNCE_EDGE_EN; otherwise RISE and FALL are tied to 0.
module switch_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic SW_IN,
   output logic SW_OUT,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_param_check
      $error("switch_debounce: STABLE_CYCLES must be at least MIN_STABLE_CYCLES");
   end

   logic             s2;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sw_out_nxt;

   sync_2ff u_sync (
      .CLK (CLK),
      .RST (RST),
      .D   (SW_IN),
      .Q   (s2)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= LOW_STABLE;
         cnt    <= '0;
         SW_OUT <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         SW_OUT <= sw_out_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sw_out_nxt = SW_OUT;
      case (state)
         LOW_STABLE: begin
            sw_out_nxt = 1'b0;
            if (s2) begin
               state_nxt = LOW_TO_HIGH;
               cnt_nxt   = CNT_W'(1);
            end
         end
         LOW_TO_HIGH: begin
            if (!s2) begin
               state_nxt = LOW_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = HIGH_STABLE;
               sw_out_nxt = 1'b1;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HIGH_STABLE: begin
            sw_out_nxt = 1'b1;
            if (!s2) begin
               state_nxt = HIGH_TO_LOW;
               cnt_nxt   = CNT_W'(1);
            end
         end
         HIGH_TO_LOW: begin
            if (s2) begin
               state_nxt = HIGH_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = LOW_STABLE;
               sw_out_nxt = 1'b0;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt  = LOW_STABLE;
            cnt_nxt    = '0;
            sw_out_nxt = 1'b0;
         end
      endcase
   end

   assign BUSY = (state == LOW_TO_HIGH) || (state == HIGH_TO_LOW);

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   // A strobe marks the edge on which qualification completes, so it coincides with SW_OUT changing.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RISE <= 1'b0;
         FALL <= 1'b0;
      end else begin
         RISE <= (state == LOW_TO_HIGH) && (state_nxt == HIGH_STABLE);
         FALL <= (state == HIGH_TO_LOW) && (state_nxt == LOW_STABLE);
      end
   end
`else
   assign RISE = 1'b0;
   assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized self-checking bench for switch_debounce (STABLE_CYCLES=4).
// The reference model counts consecutive synchronized samples that disagree with the output level.
module tb_switch_debounce;

   localparam int unsigned SC = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic SW_IN = 1'b0;
   logic SW_OUT, RISE, FALL, BUSY;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference state
   logic        m_s1 = 1'b0, m_s2 = 1'b0;
   logic        m_out = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
   int unsigned m_run = 0;

   switch_debounce #(.STABLE_CYCLES(SC)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .SW_IN  (SW_IN),
      .SW_OUT (SW_OUT),
      .RISE   (RISE),
      .FALL   (FALL),
      .BUSY   (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
      end
   endtask

   task automatic model_edge(input logic sw, input logic rst);
      logic seen;
      if (rst) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0;
         m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
      end else begin
         seen   = m_s2;
         m_s2   = m_s1;
         m_s1   = sw;
         m_rise = 1'b0;
         m_fall = 1'b0;
         m_run  = (seen != m_out) ? m_run + 1 : 0;
         if (m_run == SC) begin
            m_out  = ~m_out;
            m_rise = m_out;
            m_fall = ~m_out;
            m_run  = 0;
         end
      end
   endtask

   // Drive on negedge, advance model at posedge, sample 1 time unit later.
   task automatic step(input logic sw, input logic rst);
      @(negedge CLK);
      SW_IN = sw;
      RST   = rst;
      @(posedge CLK);
      model_edge(sw, rst);
      #1;
      check_eq("sw_out", SW_OUT, m_out);
      check_eq("busy",   BUSY,   m_run != 0);
      check_eq("rise",   RISE,   EDGE_EN & m_rise);
      check_eq("fall",   FALL,   EDGE_EN & m_fall);
      check_eq("strobe_excl", RISE & FALL, 1'b0);
   endtask

   task automatic hold(input logic sw, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(sw, 1'b0);
   endtask

   initial begin
      // Reset with the switch already pressed
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      // Rising qualification from edge 0: BUSY after edge 2, SW_OUT/RISE after edge 5
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_eq("busy_edge2", BUSY, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check_eq("sw_out_edge4", SW_OUT, 1'b0);
      step(1'b1, 1'b0);
      check_eq("sw_out_edge5", SW_OUT, 1'b1);
      check_eq("rise_edge5", RISE, EDGE_EN);
      step(1'b1, 1'b0);
      check_eq("rise_edge6", RISE, 1'b0);
      check_eq("busy_edge6", BUSY, 1'b0);
      hold(1'b1, 2);
      // Short low glitch is rejected
      hold(1'b0, 2);
      hold(1'b1, 6);
      check_eq("glitch_sw_out", SW_OUT, 1'b1);
      check_eq("glitch_busy", BUSY, 1'b0);
      // Sustained low gives one FALL after edge 5
      hold(1'b0, 5);
      step(1'b0, 1'b0);
      check_eq("fall_edge5", FALL, EDGE_EN);
      check_eq("sw_out_low", SW_OUT, 1'b0);
      hold(1'b0, 3);
      // Reset in the middle of a rising qualification (cnt=2)
      hold(1'b1, 4);
      check_eq("busy_before_rst", BUSY, 1'b1);
      step(1'b1, 1'b1);
      check_eq("busy_after_rst", BUSY, 1'b0);
      hold(1'b1, 5);
      check_eq("no_rise_yet", SW_OUT, 1'b0);
      step(1'b1, 1'b0);
      check_eq("rise_after_rst", RISE, EDGE_EN);
      check_eq("sw_out_after_rst", SW_OUT, 1'b1);
      // Random runs of varying length, including occasional resets
      for (int unsigned r = 0; r < 120; r++) begin
         logic lvl;
         int unsigned len;
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 7);
         if ($urandom_range(0, 19) == 0) step(lvl, 1'b1);
         hold(lvl, len);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Debounces one asynchronous mechanical input (push-button or slide switch) and produces a clean level plus single-cycle edge strobes. It sits directly upstream of the design's D flip-flop stage: SW_OUT drives that register's D input, and RISE/FALL feed its load/enable logic. The block contains a two-flop synchronizer, a stability counter and a four-state FSM.

## Interface
- STABLE_CYCLES, default 4: consecutive synchronized cycles a new input level must persist before SW_OUT follows; legal range ≥ 2.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- SW_IN  input  1  raw asynchronous switch level.
- SW_OUT  output  1  debounced level, registered.
- RISE  output  1  one-cycle strobe coincident with SW_OUT going 0→1.
- FALL  output  1  one-cycle strobe coincident with SW_OUT going 1→0.
- BUSY  output  1  high while a candidate transition is being qualified.

## Operation
- Synchronizer: s1 <= SW_IN; s2 <= s1. Only s2 is used downstream.
- Counter width: CNT_W = $clog2(STABLE_CYCLES). Unsigned. It never wraps because it is cleared on reaching STABLE_CYCLES-1.
- FSM states:
  - LOW_STABLE: SW_OUT=0. If s2=1, go to LOW_TO_HIGH with cnt=1.
  - LOW_TO_HIGH: if s2=0, return to LOW_STABLE with cnt=0 (glitch rejected). Else if cnt==STABLE_CYCLES-1, go to HIGH_STABLE, set SW_OUT=1, pulse RISE, and clear cnt. Else increment cnt.
  - HIGH_STABLE and HIGH_TO_LOW: mirror images of the two states above, with FALL as the strobe.
- BUSY=1 in LOW_TO_HIGH and HIGH_TO_LOW; BUSY=0 otherwise.
- RISE and FALL are never both high. Each is high for exactly one cycle per accepted transition.
- An input that returns to the stable level before qualification restarts the count from zero. Partial counts never accumulate.
- Reset values: s1=0, s2=0, cnt=0, state=LOW_STABLE, SW_OUT=0, RISE=0, FALL=0, BUSY=0.
- Reset asserted mid-qualification or in HIGH_STABLE: on the next edge all registers take their reset values. If SW_IN is still high after RST deasserts, it is requalified from scratch, and a RISE is produced.

## Timing
- SW_IN is sampled into s1 at edge 0 and then held. SW_OUT and RISE/FALL update at edge STABLE_CYCLES+1. Total latency is STABLE_CYCLES+2 edges counting edge 0.
- All outputs are registered. There is no combinational path from SW_IN.
- A glitch shorter than STABLE_CYCLES cycles at s2 produces no output change and no strobe.
- If SW_IN toggles on the same edge that qualification completes, the transition is still accepted. The new level then starts a fresh qualification in the following state.

## Configuration
- Macro: SWITCH_DEBOUNCE_EDGE_EN.
- Defined: RISE and FALL behave as specified above.
- Undefined: the edge-strobe registers are not built. RISE and FALL remain as ports, tied to constant 0. SW_OUT and BUSY timing is unchanged.

## Structure
- Package debounce_pkg:
  - typedef enum logic [1:0] db_state_t {LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW}.
  - localparam MIN_STABLE_CYCLES = 2, used by an elaboration-time check on STABLE_CYCLES.
- Sub-module sync_2ff (CLK, RST, D, Q): a two-flop synchronizer with synchronous active-high reset to 0. It is instantiated once and is reusable elsewhere.

## Test plan
All scenarios use STABLE_CYCLES=4. Stimulus changes on negedge CLK; checks are made #1 after posedge.
1. RST=1 for 2 cycles with SW_IN=1 → SW_OUT=0, RISE=0, FALL=0, BUSY=0 throughout reset.
2. RST=0, SW_IN held 0→1 at edge 0 → BUSY=1 after edge 2; SW_OUT=1 and RISE=1 after edge 5; RISE=0 and BUSY=0 after edge 6.
3. With SW_OUT=1, pulse SW_IN low for 2 cycles, then return high → SW_OUT stays 1, FALL never asserts, and BUSY returns to 0.
4. With SW_OUT=1, SW_IN=0 held → FALL=1 for exactly one cycle, after edge 5; SW_OUT=0 thereafter.
5. Assert RST while in LOW_TO_HIGH with cnt=2, SW_IN held 1 → after the reset edge, state=LOW_STABLE and cnt=0. After RST drops, RISE occurs 6 edges later.
6. Build without SWITCH_DEBOUNCE_EDGE_EN, repeat scenarios 2 and 4 → SW_OUT timing is identical, and RISE=FALL=0 on every cycle.
